vco_fp_mc: RTL and testbench
============================

# vco_fp_mc

Multi-channel, parametrised fixed-point harmonic-oscillator VCO for the analog-behavioural model library. It integrates NCH independent oscillators (dv/dt = −w²·x, dx/dt = v) with explicit Euler at a fixed step DT. One multiplier is time-shared across all channels. A step is started by a request/done handshake instead of free-running every clock, and per-channel initial conditions can be loaded at run time.

## Interface
- NCH, 4: number of oscillator channels (≥1)
- DW, 14: signed width of x and v state per channel
- WW, 17: unsigned width of each frequency word w
- WF, 10: fraction bits of w
- DT, 10485: unsigned Euler step constant
- DTF, 20: fraction bits of DT
- X0, 6471: reset value of every channel's x
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- step  in  1  request one Euler step of all channels
- w  in  NCH*WW  frequency words; channel k at bits [k*WW +: WW]
- load  in  1  write initial condition (IDLE only)
- load_ch  in  clog2(NCH)  channel to load
- load_x, load_v  in  DW each  values to load
- busy  out  1  step in progress
- done  out  1  one-cycle pulse when a step completes
- x_out, v_out  out  NCH*DW each  registered state; channel k at [k*DW +: DW]

## Operation
- FSM states: IDLE, W2, ACC, DV, DX, WB. Channel index ch counts 0..NCH−1.
- IDLE with step=1: latch all of w into a snapshot, set ch=0, go to W2. Later changes on w do not affect the step in progress.
- Per channel, one shared multiply per state:
  - W2: w2 = (w_k·w_k) >> WF, unsigned.
  - ACC: a = −((w2·x_k) >> WF), signed, full width.
  - DV: dv = (a·DT) >> DTF.
  - DX: dx = (v_k·DT) >> DTF.
  - WB: v_k ← v_k + dv and x_k ← x_k + dx, both using the pre-step v_k and x_k (explicit Euler).
- WB transitions to W2 with ch+1, or to IDLE with done=1 after channel NCH−1.
- All right shifts are arithmetic (floor). Intermediates keep full precision. dv and dx are truncated to DW bits only at the final add.
- Final add is two's-complement wrap by default; see Configuration.
- load=1 in IDLE with step=0: x_k ← load_x, v_k ← load_v for k = load_ch. load_ch ≥ NCH is ignored.
- load while busy is ignored. If step and load are both high in IDLE, step wins and load is dropped.
- step while busy is ignored and is not queued.
- Reset:
  - x_k = X0, v_k = 0 for all k.
  - FSM = IDLE, busy = 0, done = 0.
  - Reset mid-step aborts the step; channels already written back are also reset to the reset values.

## Timing
- step sampled at edge E0. Cycle n is the cycle after edge En.
- busy=1 in cycles 0..5·NCH−1.
- Channel k's state updates at edge E(5k+5), visible on x_out/v_out in cycle 5k+5.
- done=1 and busy=0 in cycle 5·NCH (cycle 20 for NCH=4).
- A step asserted during the done cycle is accepted, so back-to-back throughput is one step per 5·NCH+1 cycles.
- load takes effect on x_out/v_out the cycle after it is sampled.

## Configuration
- VCO_SAT_EN defined: the WB adds saturate to [−2^(DW−1), 2^(DW−1)−1].
- VCO_SAT_EN undefined: the WB adds wrap modulo 2^DW.
- Nothing else changes, including latency.

## Test plan
- Reset, then idle: all x_out = 6471, all v_out = 0, busy = 0, done = 0.
- w0 = 1024, two steps:
  - after step 1: x0 = 6471, v0 = −65
  - after step 2: x0 = 6470, v0 = −130
  - done pulses in cycle 20 after each step
- All w = 0, one step: all states unchanged, done pulses once.
- Load ch2 with x = 8191, v = 8191, w2 = 0, one step:
  - x2 = −8112 without VCO_SAT_EN
  - x2 = 8191 with VCO_SAT_EN
- step re-asserted in cycle 7 and load pulsed in cycle 9: exactly one done pulse, load has no effect. step asserted in the done cycle starts a new step.
- reset asserted in cycle 12 of a step: next cycle all x = 6471, v = 0, busy = 0, and no done pulse.

Source files
------------

// File: rtl/vco_fp_mc_if.sv
// Bundles the step/load/state signals of vco_fp_mc.
// The master drives requests and loads; the slave (the oscillator) returns status and state.
interface vco_fp_mc_if #(
  parameter int NCH = 4,
  parameter int DW  = 14,
  parameter int WW  = 17
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                  step;
  logic [NCH*WW-1:0]     w;
  logic                  load;
  logic [CW-1:0]         load_ch;
  logic signed [DW-1:0]  load_x;
  logic signed [DW-1:0]  load_v;
  logic                  busy;
  logic                  done;
  logic [NCH*DW-1:0]     x_out;
  logic [NCH*DW-1:0]     v_out;

  modport master (
    output step, w, load, load_ch, load_x, load_v,
    input  busy, done, x_out, v_out
  );

  modport slave (
    input  step, w, load, load_ch, load_x, load_v,
    output busy, done, x_out, v_out
  );
endinterface

// File: rtl/vco_fp_mc.sv
// Multi-channel fixed-point harmonic oscillator, explicit Euler, one shared multiplier.
// Define VCO_SAT_EN to make the write-back adds saturate instead of wrap.
module vco_fp_mc #(
  parameter int          NCH = 4,
  parameter int          DW  = 14,
  parameter int          WW  = 17,
  parameter int          WF  = 10,
  parameter int unsigned DT  = 10485,
  parameter int          DTF = 20,
  parameter int          X0  = 6471
) (
  input logic         clk,
  input logic         reset,
  vco_fp_mc_if.slave  bus
);

  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DTW = $clog2(DT + 1);
  localparam int W2W = 2*WW - WF;            // unsigned width of w^2 >> WF
  localparam int AW  = W2W + DW - WF + 2;    // signed width of the negated acceleration
  localparam int OA0 = (WW + 1 > W2W + 1) ? WW + 1 : W2W + 1;
  localparam int OA1 = (OA0 > AW) ? OA0 : AW;
  localparam int OA  = (OA1 > DW) ? OA1 : DW;
  localparam int OB0 = (WW + 1 > DW) ? WW + 1 : DW;
  localparam int OB  = (OB0 > DTW + 1) ? OB0 : DTW + 1;
  localparam int PW  = OA + OB;

  typedef enum logic [2:0] {IDLE, W2, ACC, DV, DX, WB} state_t;

  state_t                state;
  logic [CW-1:0]         ch;
  logic [NCH*WW-1:0]     w_snap;
  logic signed [DW-1:0]  x_r [NCH];
  logic signed [DW-1:0]  v_r [NCH];
  logic signed [PW-1:0]  w2_r, a_r, dv_r, dx_r;
  logic                  busy_r, done_r;

  logic [WW-1:0]         w_k;
  logic signed [DW-1:0]  x_k, v_k;
  logic signed [OA-1:0]  op_a;
  logic signed [OB-1:0]  op_b;
  logic signed [PW-1:0]  prod;

  assign w_k  = w_snap[ch*WW +: WW];
  assign x_k  = x_r[ch];
  assign v_k  = v_r[ch];
  assign prod = op_a * op_b;

  function automatic logic signed [DW-1:0] wb_add(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
    logic signed [DW:0] sum;
    sum = (DW+1)'(a) + (DW+1)'(b);
`ifdef VCO_SAT_EN
    if (sum[DW] != sum[DW-1])
      return sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return sum[DW-1:0];
`else
    return sum[DW-1:0];
`endif
  endfunction

  // Operand routing for the single time-shared multiplier.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves an operand unassigned (no latch).
    op_a = '0;
    op_b = '0;
    case (state)
      W2:  begin op_a = OA'(w_k);         op_b = OB'(w_k); end
      ACC: begin op_a = w2_r[OA-1:0];     op_b = OB'(x_k); end
      DV:  begin op_a = a_r[OA-1:0];      op_b = OB'(DT);  end
      DX:  begin op_a = OA'(v_k);         op_b = OB'(DT);  end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ch     <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      w_snap <= '0;
      w2_r   <= '0;
      a_r    <= '0;
      dv_r   <= '0;
      dx_r   <= '0;
      // NOTE: the state arrays are reset element by element; a mid-step reset must restore every channel.
      for (int k = 0; k < NCH; k++) begin
        x_r[k] <= DW'(X0);
        v_r[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.step) begin
            w_snap <= bus.w;
            ch     <= '0;
            busy_r <= 1'b1;
            state  <= W2;
          end else if (bus.load && int'(bus.load_ch) < NCH) begin
            x_r[bus.load_ch] <= bus.load_x;
            v_r[bus.load_ch] <= bus.load_v;
          end
        end
        W2: begin
          w2_r  <= prod >>> WF;
          state <= ACC;
        end
        ACC: begin
          a_r   <= -(prod >>> WF);
          state <= DV;
        end
        DV: begin
          dv_r  <= prod >>> DTF;
          state <= DX;
        end
        DX: begin
          dx_r  <= prod >>> DTF;
          state <= WB;
        end
        WB: begin
          // Both updates use the pre-step x_k and v_k.
          v_r[ch] <= wb_add(v_k, dv_r[DW-1:0]);
          x_r[ch] <= wb_add(x_k, dx_r[DW-1:0]);
          if (ch == CW'(NCH - 1)) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= IDLE;
          end else begin
            ch    <= ch + 1'b1;
            state <= W2;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;

  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign bus.x_out[k*DW +: DW] = x_r[k];
    assign bus.v_out[k*DW +: DW] = v_r[k];
  end

endmodule

// File: tb/tb_vco_fp_mc.sv
// Directed self-checking bench for vco_fp_mc: reset, Euler steps, loads, handshake corner cases.
// Build with VCO_SAT_EN defined to check the saturating write-back.
module tb_vco_fp_mc;
  localparam int NCH = 4;
  localparam int DW  = 14;
  localparam int WW  = 17;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   dcount = 0;

  vco_fp_mc_if #(.NCH(NCH), .DW(DW), .WW(WW)) bus ();

  vco_fp_mc #(
    .NCH(NCH), .DW(DW), .WW(WW), .WF(10), .DT(10485), .DTF(20), .X0(6471)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [DW-1:0] xo(input int k);
    return bus.x_out[k*DW +: DW];
  endfunction

  function automatic logic signed [DW-1:0] vo(input int k);
    return bus.v_out[k*DW +: DW];
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  // Advance n edges; outputs are then sampled 1 time unit after the edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      dcount += int'(bus.done);
    end
  endtask

  // Leaves the bench in cycle 0 of the new step.
  task automatic start_step();
    bus.step = 1'b1;
    run(1);
    bus.step = 1'b0;
  endtask

  initial begin
    bus.step    = 1'b0;
    bus.w       = '0;
    bus.load    = 1'b0;
    bus.load_ch = '0;
    bus.load_x  = '0;
    bus.load_v  = '0;
    reset       = 1'b1;
    run(2);
    reset = 1'b0;
    run(1);

    for (int k = 0; k < NCH; k++) begin
      check($sformatf("rst_x%0d", k), xo(k), 6471);
      check($sformatf("rst_v%0d", k), vo(k), 0);
    end
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);

    // All w = 0 with v = 0: nothing moves, one done pulse.
    start_step();
    dcount = 0;
    run(20);
    check("w0_done", bus.done, 1);
    check("w0_busy", bus.busy, 0);
    run(3);
    check("w0_dcount", dcount, 1);
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("w0_x%0d", k), xo(k), 6471);
      check($sformatf("w0_v%0d", k), vo(k), 0);
    end

    // w0 = 1024: first step, with write-back timing of channel 0.
    bus.w = '0;
    bus.w[0 +: WW] = 17'd1024;
    start_step();
    check("s1_busy_c0", bus.busy, 1);
    check("s1_done_c0", bus.done, 0);
    run(4);
    check("s1_v0_c4", vo(0), 0);
    run(1);
    check("s1_v0_c5", vo(0), -65);
    check("s1_x0_c5", xo(0), 6471);
    run(14);
    check("s1_busy_c19", bus.busy, 1);
    check("s1_done_c19", bus.done, 0);
    run(1);
    check("s1_done_c20", bus.done, 1);
    check("s1_busy_c20", bus.busy, 0);
    check("s1_x1", xo(1), 6471);
    check("s1_v1", vo(1), 0);
    run(1);
    check("s1_done_c21", bus.done, 0);

    // Second step; w changes mid-step must not matter.
    start_step();
    run(1);
    bus.w[0 +: WW] = 17'd5000;
    run(19);
    check("s2_done_c20", bus.done, 1);
    check("s2_x0", xo(0), 6470);
    check("s2_v0", vo(0), -130);
    bus.w = '0;

    // Load ch2 then step with w2 = 0: x2 overflows.
    bus.load    = 1'b1;
    bus.load_ch = 2'd2;
    bus.load_x  = 14'sd8191;
    bus.load_v  = 14'sd8191;
    run(1);
    bus.load = 1'b0;
    check("ld_x2", xo(2), 8191);
    check("ld_v2", vo(2), 8191);
    start_step();
    run(20);
    check("ld_done", bus.done, 1);
`ifdef VCO_SAT_EN
    check("ld_step_x2", xo(2), 8191);
`else
    check("ld_step_x2", xo(2), -8112);
`endif
    check("ld_step_v2", vo(2), 8191);
    check("ld_step_x0", xo(0), 6468);
    check("ld_step_v0", vo(0), -130);

    // step and load together in IDLE: step wins, load dropped.
    bus.load    = 1'b1;
    bus.load_ch = 2'd1;
    bus.load_x  = 14'sd100;
    bus.load_v  = 14'sd100;
    bus.step    = 1'b1;
    run(1);
    bus.step = 1'b0;
    bus.load = 1'b0;
    check("sl_busy", bus.busy, 1);
    run(20);
    check("sl_done", bus.done, 1);
    check("sl_x1", xo(1), 6471);
    check("sl_v1", vo(1), 0);

    // step at cycle 7 and load at cycle 9 are ignored; step in done cycle accepted.
    start_step();
    dcount = 0;
    run(7);
    bus.step = 1'b1;
    run(1);
    bus.step = 1'b0;
    run(1);
    bus.load    = 1'b1;
    bus.load_ch = 2'd3;
    bus.load_x  = 14'sd1;
    bus.load_v  = 14'sd1;
    run(1);
    bus.load = 1'b0;
    run(10);
    check("bb_done_c20", bus.done, 1);
    check("bb_dcount", dcount, 1);
    check("bb_x3", xo(3), 6471);
    check("bb_v3", vo(3), 0);
    bus.step = 1'b1;
    run(1);
    bus.step = 1'b0;
    check("bb_busy_c0", bus.busy, 1);
    check("bb_done_c0", bus.done, 0);
    dcount = 0;
    run(20);
    check("bb2_done_c20", bus.done, 1);
    run(10);
    check("bb2_busy_after", bus.busy, 0);
    check("bb2_dcount", dcount, 1);

    // Reset in cycle 12 aborts the step, including channels already written.
    bus.w = '0;
    bus.w[0 +: WW] = 17'd1024;
    start_step();
    run(12);
    reset = 1'b1;
    run(1);
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("mr_x%0d", k), xo(k), 6471);
      check($sformatf("mr_v%0d", k), vo(k), 0);
    end
    check("mr_busy", bus.busy, 0);
    check("mr_done", bus.done, 0);
    reset  = 1'b0;
    dcount = 0;
    run(25);
    check("mr_dcount", dcount, 0);
    check("mr_busy_after", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
